// File: rtl/ram8x72_fifo_ctrl_pkg.sv
// Shared sizing constants for the 8x72 RAM-backed stream FIFO controller.
// DEPTH counts RAM words; FULL_CNT adds the registered output slot.
package ram8x72_fifo_ctrl_pkg;

  localparam int unsigned DATA_W   = 72;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned FULL_CNT = DEPTH + 1;

endpackage

// File: rtl/ram8x72_fifo_ctrl.sv
// Valid/ready FIFO controller on top of an external single-port 8x72 DFF RAM.
// The head word lives in a registered output stage, giving 9 words of storage.
module ram8x72_fifo_ctrl
  import ram8x72_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = ram8x72_fifo_ctrl_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram8x72_fifo_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] RAM_WORDS = (ADDR_W + 1)'(2 ** ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;

  logic pop;
  logic slot_free;
  logic ram_empty;
  logic refill;
  logic bypass;
  logic push;
  logic write;

  always_comb begin
    pop       = out_valid && out_ready;
    slot_free = !out_valid || pop;
    ram_empty = (ram_cnt == '0);
    refill    = slot_free && !ram_empty;
    bypass    = slot_free && ram_empty && in_valid;
    // A refill read owns the RAM port, so writes are blocked that cycle.
    in_ready  = !rst && ((slot_free && ram_empty) || (!refill && (ram_cnt < RAM_WORDS)));
    push      = in_valid && in_ready;
    write     = push && !bypass;
  end

  always_comb begin
    ram_address = refill ? rd_ptr : wr_ptr;
    ram_wr_n    = !write;
    ram_wdata   = in_data;
    count       = ram_cnt + (ADDR_W + 1)'(out_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (refill) begin
        out_data <= ram_rdata;
        rd_ptr   <= rd_ptr + 1'b1;
      end else if (bypass) begin
        out_data <= in_data;
      end
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (slot_free) begin
        out_valid <= refill || bypass;
      end
      case ({write, refill})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ram8x72_fifo_ctrl.sv
// Directed bench for ram8x72_fifo_ctrl with a behavioural 8x72 RAM beside it.
module tb_ram8x72_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;
  logic [3:0]  count;
  logic        ram_wr_n;
  logic [2:0]  ram_address;
  logic [71:0] ram_wdata;
  logic [71:0] ram_rdata;

  logic [71:0] mem [8];

  int checks = 0;
  int errors = 0;

  ram8x72_fifo_ctrl #(.DATA_W(72), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_wr_n(ram_wr_n), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!ram_wr_n) mem[ram_address] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_address];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 72'h55; out_ready = 1'b0;

    // Reset held two cycles with a word offered
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_n", ram_wr_n, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_out_data", out_data, 0);

    // Single bypass into an empty FIFO
    rst = 1'b0; in_valid = 1'b1; in_data = 72'hA5; out_ready = 1'b0;
    #1;
    check("byp_in_ready", in_ready, 1);
    check("byp_wr_n", ram_wr_n, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("byp_out_valid", out_valid, 1);
    check("byp_out_data", out_data, 72'hA5);
    check("byp_count", count, 1);
    out_ready = 1'b1;
    tick();
    check("byp_pop_count", count, 0);
    check("byp_pop_valid", out_valid, 0);
    check("byp_hold_data", out_data, 72'hA5);

    // Fill: word 1 bypasses, words 2..9 land at RAM addresses 0..7
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_data = 72'(i);
      #1;
      check("fill_in_ready", in_ready, 1);
      if (i == 1) begin
        check("fill_bypass_wr_n", ram_wr_n, 1);
      end else begin
        check("fill_wr_n", ram_wr_n, 0);
        check("fill_addr", ram_address, 72'(i - 2));
      end
      tick();
    end
    check("full_count", count, 9);
    in_valid = 1'b1; in_data = 72'd10;
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_wr_n", ram_wr_n, 1);
    tick();
    check("full_count_hold", count, 9);

    // Drain in order with out_ready held high
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      #1;
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, 72'(k));
      check("drain_count", count, 72'(10 - k));
      if (k <= 8) begin
        check("drain_addr", ram_address, 72'(k - 1));
        check("drain_wr_n", ram_wr_n, 1);
        check("drain_in_ready", in_ready, 0);
      end
      tick();
    end
    check("drain_empty_valid", out_valid, 0);
    check("drain_empty_count", count, 0);

    // Wrap and contention: out_ready toggles 1,0; write pointer wraps past 7
    for (int c = 0; c <= 22; c++) begin
      int j;
      out_ready = (c % 2 == 0);
      if (c == 0) begin
        in_valid = 1'b1; in_data = 72'h101;
        #1;
        check("wrap_c0_in_ready", in_ready, 1);
        check("wrap_c0_wr_n", ram_wr_n, 1);
        check("wrap_c0_valid", out_valid, 0);
      end else if (c % 2 == 1) begin
        j = (c - 1) / 2;
        in_valid = 1'b1; in_data = 72'h100 + 72'(j + 2);
        #1;
        check("wrap_w_in_ready", in_ready, 1);
        check("wrap_w_wr_n", ram_wr_n, 0);
        check("wrap_w_addr", ram_address, 72'(j % 8));
        check("wrap_w_head", out_data, 72'h100 + 72'(j + 1));
        check("wrap_w_count", count, 1);
      end else begin
        j = (c - 2) / 2;
        in_valid = (j < 10);
        in_data = 72'h100 + 72'(j + 3);
        #1;
        check("wrap_r_in_ready", in_ready, 0);
        check("wrap_r_wr_n", ram_wr_n, 1);
        check("wrap_r_addr", ram_address, 72'(j % 8));
        check("wrap_r_head", out_data, 72'h100 + 72'(j + 1));
        check("wrap_r_count", count, 2);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("wrap_last_data", out_data, 72'h10C);
    check("wrap_last_count", count, 1);
    out_ready = 1'b1;
    tick();
    check("wrap_final_count", count, 0);

    // Mid-operation reset with five words held
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 72'h200 + 72'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("mid_count5", count, 5);
    rst = 1'b1; in_valid = 1'b1; in_data = 72'h77;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_wr_n", ram_wr_n, 1);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_count0", count, 0);
    check("mid_valid0", out_valid, 0);
    check("mid_wr_ptr0", ram_address, 0);
    in_valid = 1'b1; in_data = 72'h1;
    #1;
    check("mid_push_ready", in_ready, 1);
    check("mid_push_wr_n", ram_wr_n, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("mid_first_valid", out_valid, 1);
    check("mid_first_data", out_data, 72'h1);
    check("mid_first_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
